// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between NUM_REQ writeback sources, the shared register-file write port
// and the read-port forwarding path.
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 5,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ID_W-1:0]   req_id;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      stall;
  logic                      write_en;
  logic [ID_W-1:0]           write_id;
  logic [DATA_W-1:0]         write_data;
  logic [ID_W-1:0]           read1_id;
  logic [ID_W-1:0]           read2_id;
  logic                      fwd1_valid;
  logic [DATA_W-1:0]         fwd1_data;
  logic                      fwd2_valid;
  logic [DATA_W-1:0]         fwd2_data;

  modport master (
    output req_valid, req_id, req_data, stall, read1_id, read2_id,
    input  req_ready, write_en, write_id, write_data,
    input  fwd1_valid, fwd1_data, fwd2_valid, fwd2_data
  );

  modport slave (
    input  req_valid, req_id, req_data, stall, read1_id, read2_id,
    output req_ready, write_en, write_id, write_data,
    output fwd1_valid, fwd1_data, fwd2_valid, fwd2_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NUM_REQ writeback
// sources, with a registered write stage forwarded to both read ports.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 5,
  parameter int DATA_W  = 32
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int               PTR_W     = $clog2(NUM_REQ);
  localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]   rr_ptr_r;
  logic [PTR_W-1:0]   ptr_nxt_s;
  logic [PTR_W-1:0]   grant_idx_s;
  logic [NUM_REQ-1:0] grant_s;
  logic               grant_any_s;
  logic [ID_W-1:0]    sel_id_s;
  logic [DATA_W-1:0]  sel_data_s;
  logic               write_en_r;
  logic [ID_W-1:0]    write_id_r;
  logic [DATA_W-1:0]  write_data_r;
  logic               fwd1_hit_s;
  logic               fwd2_hit_s;

  // Scan from rr_ptr upward with wrap; first valid requester wins, nothing while in reset.
  always_comb begin : grant_scan
    logic [PTR_W:0]   sum_v;
    logic [PTR_W-1:0] idx_v;
    grant_s     = {NUM_REQ{1'b0}};
    grant_idx_s = {PTR_W{1'b0}};
    grant_any_s = 1'b0;
    sum_v       = {(PTR_W+1){1'b0}};
    idx_v       = {PTR_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_v = {1'b0, rr_ptr_r} + (PTR_W+1)'(k);
      if (sum_v >= NUM_REQ_W) begin
        sum_v = sum_v - NUM_REQ_W;
      end else begin
        sum_v = sum_v;
      end
      idx_v = sum_v[PTR_W-1:0];
      if (rst && !bus.stall && !grant_any_s && bus.req_valid[idx_v]) begin
        grant_s[idx_v] = 1'b1;
        grant_idx_s    = idx_v;
        grant_any_s    = 1'b1;
      end else begin
        grant_any_s = grant_any_s;
      end
    end
  end

  // Next pointer: one past the winner, holding when nothing is granted.
  always_comb begin
    ptr_nxt_s = rr_ptr_r;
    if (grant_any_s) begin
      ptr_nxt_s = (grant_idx_s == LAST_IDX) ? {PTR_W{1'b0}} : grant_idx_s + PTR_W'(1);
    end else begin
      ptr_nxt_s = rr_ptr_r;
    end
  end

  // One-hot grant selects the winner's id/data by AND-OR.
  always_comb begin
    sel_id_s   = {ID_W{1'b0}};
    sel_data_s = {DATA_W{1'b0}};
    for (int g = 0; g < NUM_REQ; g++) begin
      sel_id_s   = sel_id_s   | (bus.req_id[g*ID_W +: ID_W]       & {ID_W{grant_s[g]}});
      sel_data_s = sel_data_s | (bus.req_data[g*DATA_W +: DATA_W] & {DATA_W{grant_s[g]}});
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_r <= {PTR_W{1'b0}};
    end else begin
      rr_ptr_r <= ptr_nxt_s;
    end
  end

  // Write stage; x0 writes are accepted but never enabled, and reset drops a pending write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_en_r   <= 1'b0;
      write_id_r   <= {ID_W{1'b0}};
      write_data_r <= {DATA_W{1'b0}};
    end else if (grant_any_s) begin
      write_en_r   <= (sel_id_s != {ID_W{1'b0}});
      write_id_r   <= sel_id_s;
      write_data_r <= sel_data_s;
    end else begin
      write_en_r   <= 1'b0;
    end
  end

  assign fwd1_hit_s = write_en_r && (bus.read1_id == write_id_r) && (bus.read1_id != {ID_W{1'b0}});
  assign fwd2_hit_s = write_en_r && (bus.read2_id == write_id_r) && (bus.read2_id != {ID_W{1'b0}});

  assign bus.req_ready  = grant_s;
  assign bus.write_en   = write_en_r;
  assign bus.write_id   = write_id_r;
  assign bus.write_data = write_data_r;
  assign bus.fwd1_valid = fwd1_hit_s;
  assign bus.fwd1_data  = fwd1_hit_s ? write_data_r : {DATA_W{1'b0}};
  assign bus.fwd2_valid = fwd2_hit_s;
  assign bus.fwd2_data  = fwd2_hit_s ? write_data_r : {DATA_W{1'b0}};
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a bench-side round-robin model queues the
// expected write for each cycle; directed scenarios plus a randomised back-to-back run.
module tb_regfile_wb_arbiter;
  localparam int N  = 3;
  localparam int IW = 5;
  localparam int DW = 32;

  typedef struct packed {
    logic          en;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } wr_t;

  logic clk;
  logic rst;
  regfile_wb_arbiter_if #(.NUM_REQ(N), .ID_W(IW), .DATA_W(DW)) bus ();

  regfile_wb_arbiter #(.NUM_REQ(N), .ID_W(IW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            m_ptr  = 0;
  logic [IW-1:0] m_id   = '0;
  logic [DW-1:0] m_data = '0;
  logic [N-1:0]  last_g = '0;
  wr_t           exp_q[$];

  function automatic logic [N-1:0] model_grant(input logic [N-1:0] v, input logic s, input int p);
    logic [N-1:0] r;
    bit           done;
    int           i;
    r    = '0;
    done = 1'b0;
    if (!s) begin
      for (int k = 0; k < N; k++) begin
        i = (p + k) % N;
        if (!done && v[i]) begin
          r[i] = 1'b1;
          done = 1'b1;
        end
      end
    end
    return r;
  endfunction

  task automatic set_req(input int i, input logic [IW-1:0] id, input logic [DW-1:0] data);
    bus.req_id[i*IW +: IW]   = id;
    bus.req_data[i*DW +: DW] = data;
  endtask

  // Model one clock edge: record the grant, move the pointer, queue next cycle's write.
  task automatic advance();
    logic [N-1:0] g;
    wr_t          e;
    g      = model_grant(bus.req_valid, bus.stall, m_ptr);
    e.en   = 1'b0;
    e.id   = m_id;
    e.data = m_data;
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        m_id   = bus.req_id[i*IW +: IW];
        m_data = bus.req_data[i*DW +: DW];
        e.en   = (m_id != 5'd0);
        e.id   = m_id;
        e.data = m_data;
        m_ptr  = (i == N-1) ? 0 : i + 1;
      end
    end
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    last_g = g;
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_id   = '0;
    m_data = '0;
    last_g = '0;
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    bus.req_valid = 3'b111;
    bus.stall     = 1'b0;
    set_req(0, 5'd1, 32'h11);
    set_req(1, 5'd2, 32'h22);
    set_req(2, 5'd3, 32'h33);
    bus.read1_id  = 5'd0;
    bus.read2_id  = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 3'b000) begin
      errors++; $display("FAIL reset_ready got=%b exp=000", bus.req_ready);
    end
    checks++;
    if ({bus.write_en, bus.write_id, bus.write_data} !== 38'd0) begin
      errors++; $display("FAIL reset_write got=%b/%0d/%h exp=0/0/0", bus.write_en, bus.write_id, bus.write_data);
    end
    checks++;
    if ({bus.fwd1_valid, bus.fwd1_data, bus.fwd2_valid, bus.fwd2_data} !== 66'd0) begin
      errors++; $display("FAIL reset_fwd got=%b/%h %b/%h exp=0", bus.fwd1_valid, bus.fwd1_data, bus.fwd2_valid, bus.fwd2_data);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 3'b000;
    rst           = 1'b1;
    model_reset();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] seq;
    wr_t          e;
    bus.req_valid = 3'b111;
    set_req(0, 5'd1, 32'hA0);
    set_req(1, 5'd2, 32'hA1);
    set_req(2, 5'd3, 32'hA2);
    for (int c = 0; c < 7; c++) begin
      if (c == 6) bus.req_valid = 3'b000;
      seq = (c == 6) ? 3'b000 : (3'b001 << (c % 3));
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (bus.req_ready !== seq) begin
        errors++; $display("FAIL rr_ready cyc=%0d got=%b exp=%b", c, bus.req_ready, seq);
      end
      checks++;
      if ({bus.write_en, bus.write_id, bus.write_data} !== e || (c > 0 && bus.write_en !== 1'b1)) begin
        errors++; $display("FAIL rr_write cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, bus.write_en, bus.write_id, bus.write_data, e.en, e.id, e.data);
      end
      advance();
    end
  endtask

  task automatic test_single();
    wr_t e;
    bus.req_valid = 3'b001;
    set_req(0, 5'd5, 32'hDEAD);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (bus.req_ready !== ((c == 0) ? 3'b001 : 3'b000)) begin
        errors++; $display("FAIL single_ready cyc=%0d got=%b", c, bus.req_ready);
      end
      checks++;
      if ({bus.write_en, bus.write_id, bus.write_data} !== e ||
          (c == 1 && {bus.write_en, bus.write_id, bus.write_data} !== {1'b1, 5'd5, 32'hDEAD})) begin
        errors++; $display("FAIL single_write cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, bus.write_en, bus.write_id, bus.write_data, e.en, e.id, e.data);
      end
      advance();
      bus.req_valid = 3'b000;
    end
  endtask

  task automatic test_x0_discard();
    wr_t          e;
    logic [N-1:0] exp_r [3];
    logic [N-1:0] stim  [3];
    stim[0] = 3'b010; stim[1] = 3'b111; stim[2] = 3'b000;
    exp_r[0] = 3'b010; exp_r[1] = 3'b100; exp_r[2] = 3'b000;
    set_req(0, 5'd6, 32'h60);
    set_req(1, 5'd0, 32'h7);
    set_req(2, 5'd8, 32'h80);
    for (int c = 0; c < 3; c++) begin
      bus.req_valid = stim[c];
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (bus.req_ready !== exp_r[c]) begin
        errors++; $display("FAIL x0_ready cyc=%0d got=%b exp=%b", c, bus.req_ready, exp_r[c]);
      end
      checks++;
      if ({bus.write_en, bus.write_id, bus.write_data} !== e || (c == 1 && bus.write_en !== 1'b0)) begin
        errors++; $display("FAIL x0_write cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, bus.write_en, bus.write_id, bus.write_data, e.en, e.id, e.data);
      end
      advance();
    end
  endtask

  task automatic test_forwarding();
    wr_t e;
    bus.req_valid = 3'b001;
    set_req(0, 5'd9, 32'h55);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (bus.req_ready !== 3'b001) begin
      errors++; $display("FAIL fwd_ready got=%b exp=001", bus.req_ready);
    end
    advance();
    bus.req_valid = 3'b000;
    bus.read1_id  = 5'd9;
    bus.read2_id  = 5'd3;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if ({bus.fwd1_valid, bus.fwd1_data, bus.fwd2_valid, bus.fwd2_data} !== {1'b1, 32'h55, 1'b0, 32'h0}) begin
      errors++; $display("FAIL fwd_one got=%b/%h %b/%h exp=1/55 0/0", bus.fwd1_valid, bus.fwd1_data, bus.fwd2_valid, bus.fwd2_data);
    end
    bus.read2_id = 5'd9;
    #1;
    checks++;
    if ({bus.fwd1_valid, bus.fwd1_data, bus.fwd2_valid, bus.fwd2_data} !== {1'b1, 32'h55, 1'b1, 32'h55}) begin
      errors++; $display("FAIL fwd_both got=%b/%h %b/%h exp=1/55 1/55", bus.fwd1_valid, bus.fwd1_data, bus.fwd2_valid, bus.fwd2_data);
    end
    advance();
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if ({bus.fwd1_valid, bus.fwd1_data, bus.fwd2_valid} !== {1'b0, 32'h0, 1'b0} || bus.write_en !== e.en) begin
      errors++; $display("FAIL fwd_idle got=%b/%h %b en=%b", bus.fwd1_valid, bus.fwd1_data, bus.fwd2_valid, bus.write_en);
    end
    advance();
    bus.read1_id = 5'd0;
    bus.read2_id = 5'd0;
  endtask

  task automatic test_stall();
    wr_t          e;
    logic [N-1:0] exp_r [6];
    logic [N-1:0] stim  [6];
    logic         stl   [6];
    stim[0] = 3'b100; stim[1] = 3'b011; stim[2] = 3'b011; stim[3] = 3'b011; stim[4] = 3'b011; stim[5] = 3'b010;
    stl[0]  = 1'b0;   stl[1]  = 1'b1;   stl[2]  = 1'b1;   stl[3]  = 1'b1;   stl[4]  = 1'b0;   stl[5]  = 1'b0;
    exp_r[0] = 3'b100; exp_r[1] = 3'b000; exp_r[2] = 3'b000; exp_r[3] = 3'b000; exp_r[4] = 3'b001; exp_r[5] = 3'b010;
    set_req(0, 5'd10, 32'hA);
    set_req(1, 5'd11, 32'hB);
    set_req(2, 5'd12, 32'hC0FFEE);
    for (int c = 0; c < 7; c++) begin
      bus.req_valid = (c < 6) ? stim[c] : 3'b000;
      bus.stall     = (c < 6) ? stl[c] : 1'b0;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (bus.req_ready !== ((c < 6) ? exp_r[c] : 3'b000)) begin
        errors++; $display("FAIL stall_ready cyc=%0d got=%b", c, bus.req_ready);
      end
      checks++;
      if ({bus.write_en, bus.write_id, bus.write_data} !== e ||
          (c == 1 && bus.write_en !== 1'b1) || ((c == 2 || c == 3) && bus.write_en !== 1'b0)) begin
        errors++; $display("FAIL stall_write cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, bus.write_en, bus.write_id, bus.write_data, e.en, e.id, e.data);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_op();
    wr_t e;
    bus.req_valid = 3'b010;
    set_req(1, 5'd17, 32'h1234);
    bus.read1_id  = 5'd17;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (bus.req_ready !== 3'b010) begin
      errors++; $display("FAIL midrst_grant got=%b exp=010", bus.req_ready);
    end
    advance();
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.write_en, bus.req_ready, bus.fwd1_valid} !== 5'b0) begin
      errors++; $display("FAIL midrst_async got en=%b ready=%b fwd1=%b exp=0/000/0", bus.write_en, bus.req_ready, bus.fwd1_valid);
    end
    @(posedge clk);
    #1;
    rst           = 1'b1;
    bus.req_valid = 3'b111;
    set_req(0, 5'd20, 32'h200);
    set_req(2, 5'd22, 32'h222);
    model_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (bus.req_ready !== ((c == 0) ? 3'b001 : 3'b000)) begin
        errors++; $display("FAIL midrst_first cyc=%0d got=%b", c, bus.req_ready);
      end
      checks++;
      if ({bus.write_en, bus.write_id, bus.write_data} !== e) begin
        errors++; $display("FAIL midrst_write cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, bus.write_en, bus.write_id, bus.write_data, e.en, e.id, e.data);
      end
      advance();
      bus.req_valid = 3'b000;
    end
    bus.read1_id = 5'd0;
  endtask

  task automatic test_back_to_back();
    wr_t          e;
    logic [N-1:0] v;
    logic [N-1:0] exp_r;
    logic         f1;
    logic         f2;
    for (int c = 0; c < 301; c++) begin
      v = bus.req_valid;
      for (int i = 0; i < N; i++) begin
        if (!v[i] || last_g[i]) begin
          v[i] = (c < 300) && ($urandom_range(0, 2) != 0);
          set_req(i, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom());
        end
      end
      bus.req_valid = v;
      bus.stall     = (c < 300) && ($urandom_range(0, 4) == 0);
      bus.read1_id  = ($urandom_range(0, 1) == 1) ? m_id : 5'($urandom_range(0, 31));
      bus.read2_id  = ($urandom_range(0, 1) == 1) ? m_id : 5'($urandom_range(0, 31));
      exp_r = model_grant(bus.req_valid, bus.stall, m_ptr);
      @(negedge clk);
      e  = exp_q.pop_front();
      f1 = e.en && (bus.read1_id == e.id) && (bus.read1_id != 5'd0);
      f2 = e.en && (bus.read2_id == e.id) && (bus.read2_id != 5'd0);
      checks++;
      if (bus.req_ready !== exp_r) begin
        errors++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", c, bus.req_ready, exp_r);
      end
      checks++;
      if ({bus.write_en, bus.write_id, bus.write_data} !== e) begin
        errors++; $display("FAIL b2b_write cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, bus.write_en, bus.write_id, bus.write_data, e.en, e.id, e.data);
      end
      checks++;
      if ({bus.fwd1_valid, bus.fwd1_data, bus.fwd2_valid, bus.fwd2_data} !==
          {f1, f1 ? e.data : 32'h0, f2, f2 ? e.data : 32'h0}) begin
        errors++; $display("FAIL b2b_fwd cyc=%0d got=%b/%h %b/%h exp=%b %b data=%h", c, bus.fwd1_valid, bus.fwd1_data, bus.fwd2_valid, bus.fwd2_data, f1, f2, e.data);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_x0_discard();
    test_forwarding();
    test_stall();
    test_reset_mid_op();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench time limit");
  end
endmodule
